// File: rtl/imm_operand_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imm_operand_sequencer_if - requester, shared-extender and result signals   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface imm_operand_sequencer_if;
  logic        req0_valid;
  logic [7:0]  req0_imm;
  logic [1:0]  req0_mode;
  logic        req0_ready;
  logic        req1_valid;
  logic [7:0]  req1_imm;
  logic [1:0]  req1_mode;
  logic        req1_ready;
  logic [7:0]  se_in;
  logic [15:0] se_out;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_id;
  logic        res_ready;
  logic        busy;
  logic        err_mode;

  modport master (
    output req0_valid, req0_imm, req0_mode, req1_valid, req1_imm, req1_mode,
    output res_ready, se_out,
    input  req0_ready, req1_ready, se_in, res_valid, res_data, res_id, busy, err_mode
  );

  modport slave (
    input  req0_valid, req0_imm, req0_mode, req1_valid, req1_imm, req1_mode,
    input  res_ready, se_out,
    output req0_ready, req1_ready, se_in, res_valid, res_data, res_id, busy, err_mode
  );
endinterface
`default_nettype wire

// File: rtl/imm_operand_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imm_operand_sequencer - round-robin sharing of one 8->16 sign extender     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module imm_operand_sequencer (
  input  logic                          clk,
  input  logic                          rst_n,
  imm_operand_sequencer_if.slave        bus
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_LONG_LO = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_res_valid;
  logic [15:0] r_res_data;
  logic        r_res_id;
  logic        r_last_grant;
  logic [7:0]  r_hi;
  logic        r_owner;
  logic        r_err_mode;

  logic        w_grant0;
  logic        w_grant1;
  logic        w_free;
  logic        w_acc0;
  logic        w_acc1;
  logic        w_acc;
  logic        w_acc_id;
  logic [7:0]  w_acc_imm;
  logic [1:0]  w_acc_mode;
  logic        w_short_se;
  logic        w_load;
  logic [15:0] w_load_data;
  logic        w_hi_load;
  logic        w_err_set;

  // In LONG_LO only the owner of the pending high byte may be granted.
  always_comb begin : p_grant
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (r_state == ST_LONG_LO) begin
      w_grant0 = !r_owner && bus.req0_valid;
      w_grant1 = r_owner && bus.req1_valid;
    end else begin
      w_grant0 = bus.req0_valid && (!bus.req1_valid || r_last_grant);
      w_grant1 = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
    end
  end

  assign w_free     = !r_res_valid || bus.res_ready;
  assign w_acc0     = w_grant0 && w_free;
  assign w_acc1     = w_grant1 && w_free;
  assign w_acc      = w_acc0 || w_acc1;
  assign w_acc_id   = w_acc1;
  assign w_acc_imm  = w_acc1 ? bus.req1_imm : bus.req0_imm;
  assign w_acc_mode = w_acc1 ? bus.req1_mode : bus.req0_mode;
  assign w_short_se = w_acc && (r_state == ST_IDLE) &&
                      ((w_acc_mode == 2'd0) || (w_acc_mode == 2'd3));

  // Combinational outputs are gated so everything reads 0 while reset is held.
  assign bus.se_in      = (rst_n && w_short_se) ? w_acc_imm : 8'h00;
  assign bus.req0_ready = rst_n && w_acc0;
  assign bus.req1_ready = rst_n && w_acc1;

  always_comb begin : p_next
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_data = 16'h0000;
    w_hi_load   = 1'b0;
    w_err_set   = 1'b0;
    if (w_acc) begin
      case (r_state)
        ST_LONG_LO: begin
          w_load      = 1'b1;
          w_load_data = {r_hi, w_acc_imm};
          w_state_nxt = ST_IDLE;
        end
        default: begin
          case (w_acc_mode)
            2'd1: begin
              w_load      = 1'b1;
              w_load_data = {8'h00, w_acc_imm};
            end
            2'd2: begin
              w_hi_load   = 1'b1;
              w_state_nxt = ST_LONG_LO;
            end
            default: begin
              w_load      = 1'b1;
              w_load_data = bus.se_out;
              w_err_set   = (w_acc_mode == 2'd3);
            end
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_res_valid  <= 1'b0;
      r_res_data   <= 16'h0000;
      r_res_id     <= 1'b0;
      r_last_grant <= 1'b1;
      r_hi         <= 8'h00;
      r_owner      <= 1'b0;
      r_err_mode   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_res_valid  <= 1'b1;
        r_res_data   <= w_load_data;
        r_res_id     <= w_acc_id;
        r_last_grant <= w_acc_id;
      end else if (bus.res_ready) begin
        r_res_valid  <= 1'b0;
      end
      if (w_hi_load) begin
        r_hi    <= w_acc_imm;
        r_owner <= w_acc_id;
      end
      if (w_err_set) begin
        r_err_mode <= 1'b1;
      end
    end
  end

  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.res_id    = r_res_id;
  assign bus.busy      = (r_state == ST_LONG_LO) || r_res_valid;
  assign bus.err_mode  = r_err_mode;

endmodule
`default_nettype wire

// File: doc/imm_operand_sequencer.md
# imm_operand_sequencer

Controller that shares the single `sign_extender_8in_16out` instance in the processor datapath between two immediate requesters: requester 0 (ALU immediate path) and requester 1 (branch-offset unit). It accepts 8-bit immediate beats over valid/ready handshakes and arbitrates round-robin. It drives the shared sign extender's input, or performs zero-extension or two-beat 16-bit immediate assembly internally, and returns a registered 16-bit operand tagged with the requester ID.

## Interface
- No parameters; widths fixed (8-bit in, 16-bit out) to match the shared extender.

- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `req0_valid` in 1 — requester 0 beat valid.
- `req0_imm` in 8 — requester 0 immediate byte.
- `req0_mode` in 2 — 0 = sign-extend, 1 = zero-extend, 2 = long (two beats, high byte first), 3 = reserved.
- `req0_ready` out 1 — requester 0 beat accepted this cycle when high with valid.
- `req1_valid`, `req1_imm`, `req1_mode`, `req1_ready` — same for requester 1.
- `se_in` out 8 — drives the shared sign extender input.
- `se_out` in 16 — shared sign extender output (combinational).
- `res_valid` out 1 — result available.
- `res_data` out 16 — result operand.
- `res_id` out 1 — requester that produced the result.
- `res_ready` in 1 — consumer accepts result.
- `busy` out 1 — high in LONG_LO state or while res_valid is held.
- `err_mode` out 1 — sticky; set when a mode-3 beat is accepted.

## Operation
- States: IDLE, LONG_LO. The result register (`res_valid`, `res_data`, `res_id`) is separate from the state.
- Output space free (`free`) = `!res_valid || res_ready`.
- IDLE grant:
  - If only one requester is valid, grant it.
  - If both are valid, grant the one not granted last (`last_grant`).
  - `reqK_ready` = grant_K && free. Ready depends combinationally on valid.
- On acceptance in IDLE with mode 0 or 3:
  - `se_in` = accepted byte.
  - `res_data` <= `se_out`.
  - Mode 3 additionally sets `err_mode`.
- On acceptance with mode 1: `res_data` <= {8'h00, byte}. The shared extender is not used.
- On acceptance with mode 2:
  - Store byte as `hi`; record owner.
  - Go to LONG_LO; no result is produced.
- LONG_LO:
  - Only the owner's ready may assert (owner ready = owner valid && free); the other requester's ready is forced 0.
  - Second beat: `res_data` <= {hi, byte}. The second beat's mode is ignored.
  - Return to IDLE.
- Every result load sets `res_valid` = 1, `res_id` = granted ID, and `last_grant` = granted ID. The long case updates `last_grant` on the second beat only.
- `res_valid` clears on `res_valid && res_ready` unless a new result loads the same cycle, in which case it stays 1 with new data.
- `se_in` = 0 whenever no mode-0/3 beat is being accepted.

## Timing
- Reset (async assert, sync use after deassert):
  - State IDLE.
  - `res_valid`, `res_data`, `res_id`, `busy`, `err_mode`, `se_in`, both readys = 0.
  - `last_grant` = 1, so requester 0 wins the first tie.
- Latency:
  - Short modes: beat accepted at edge N, so `res_valid` is high from N+1.
  - Long mode: second beat accepted at edge M, so `res_valid` is high from M+1.
- Throughput:
  - One short result per cycle when `res_ready` is held high (back-to-back accept in the same cycle as the result handshake).
  - Long mode: one result per two accepted beats.
- Backpressure: while `res_valid && !res_ready`, both readys are 0 and `res_data`/`res_id` are stable.
- Long mode, first beat: accepting the high byte does not need free output space only if `res_valid` is 0; otherwise it waits like any beat (ready = free).
- Long mode, gaps: LONG_LO holds indefinitely through owner-valid gaps; the other requester stalls.
- Reset mid-long: reset in LONG_LO discards `hi`, returns to IDLE, and produces no result.
- `err_mode` clears only on reset.

## Test plan
- **Short modes, both requesters:** req0 mode 0 `8'h83` -> next cycle `res_data` `16'hFF83`, `res_id` 0; req1 mode 1 `8'h83` -> `16'h0083`, `res_id` 1; mode 0 `8'h7F` -> `16'h007F`.
- **Tie arbitration:** both valid continuously, mode 0 (`8'h01` / `8'h80`), `res_ready`=1 -> after reset, results alternate id 0,1,0,1 every cycle, data `16'h0001` / `16'hFF80`.
- **Long assembly:** req1 mode 2 `8'hAB` then `8'hCD`, with req0 valid throughout -> `req0_ready` stays 0 during LONG_LO; result `16'hABCD`, id 1; req0 granted next.
- **Backpressure:** `res_ready`=0 for 4 cycles after a result -> readys 0, `res_data` stable, `busy`=1; raising `res_ready` with a new beat pending loads the new result on the same edge.
- **Error and reset:** mode 3 `8'hF0` -> result `16'hFFF0`, `err_mode`=1 and sticky; `rst_n` low asynchronously in LONG_LO -> all outputs 0 immediately, no result after release.
